// File: rtl/conv_weight_stream_tx.sv
// Reads a full conv weight set from a synchronous-read memory and streams it one word per cycle.
// Optional running checksum output enabled by defining CONV_WEIGHT_TX_CHKSUM_EN.
module conv_weight_stream_tx #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned KERNEL          = 7,
    parameter int unsigned CHANNEL_NUM_IN  = 3,
    parameter int unsigned CHANNEL_NUM_OUT = 64,
    parameter int unsigned ADDR_WIDTH      = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hold,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  valid_weight_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  last_out,
    output logic                  busy,
    output logic                  done
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] chksum_out
`endif
);

    localparam int unsigned TOTAL = KERNEL * KERNEL * CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    issue;
    // Stage 1: a read is in flight and its data is on mem_rd_data this cycle.
    logic                    rd_pend_q;
    logic                    rd_last_q;
    // Stage 2: registered output word.
    logic                    valid_q;
    logic                    last_q;
    logic [DATA_WIDTH-1:0]   weight_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d = StStream;
                    addr_d  = '0;
                end
            end
            StStream: begin
                issue = !hold;
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            // Final word leaves the output register in the cycle stage 1 goes empty.
            StDrain: begin
                if (!rd_pend_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            weight_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_pend_q <= issue;
            rd_last_q <= issue && (addr_q == LAST_ADDR);
            valid_q   <= rd_pend_q;
            last_q    <= rd_last_q;
            if (rd_pend_q) begin
                weight_q <= mem_rd_data;
            end
        end
    end

`ifdef CONV_WEIGHT_TX_CHKSUM_EN
    logic [DATA_WIDTH-1:0] chksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chksum_q <= '0;
        end else if (state_q == StIdle && start) begin
            chksum_q <= '0;
        end else if (valid_q) begin
            chksum_q <= chksum_q + weight_q;
        end
    end

    assign chksum_out = chksum_q;
`endif

    assign mem_rd_en        = issue;
    assign mem_addr         = addr_q;
    assign valid_weight_out = valid_q;
    assign weight_out       = weight_q;
    assign last_out         = last_q;

endmodule

// File: tb/tb_conv_weight_stream_tx.sv
// Directed bench: a small 36-word instance with hold/restart/reset scenarios and a full-size
// instance streaming 9408 words.
module tb_conv_weight_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Small instance: K=3, CIN=2, COUT=2 -> 36 words, mem[n] = n + 100.
    logic        s_reset, s_start, s_hold, s_rd_en, s_valid, s_last, s_busy, s_done;
    logic [5:0]  s_addr;
    logic [31:0] s_rd_data, s_weight;
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
    logic [31:0] s_chksum;
`endif

    conv_weight_stream_tx #(
        .DATA_WIDTH(32), .KERNEL(3), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .ADDR_WIDTH(6)
    ) u_small (
        .clk(clk), .reset(s_reset), .start(s_start), .hold(s_hold),
        .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rd_data(s_rd_data),
        .valid_weight_out(s_valid), .weight_out(s_weight), .last_out(s_last),
        .busy(s_busy), .done(s_done)
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
        , .chksum_out(s_chksum)
`endif
    );

    always_ff @(posedge clk) if (s_rd_en) s_rd_data <= 32'(s_addr) + 32'd100;

    // Default-size instance: 9408 words, mem[n] = n.
    logic        b_reset, b_start, b_hold, b_rd_en, b_valid, b_last, b_busy, b_done;
    logic [13:0] b_addr;
    logic [31:0] b_rd_data, b_weight;
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
    logic [31:0] b_chksum;
`endif

    conv_weight_stream_tx u_big (
        .clk(clk), .reset(b_reset), .start(b_start), .hold(b_hold),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rd_data),
        .valid_weight_out(b_valid), .weight_out(b_weight), .last_out(b_last),
        .busy(b_busy), .done(b_done)
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
        , .chksum_out(b_chksum)
`endif
    );

    always_ff @(posedge clk) if (b_rd_en) b_rd_data <= 32'(b_addr);

    // Scenario observations (cycle c = period after the c-th posedge of the run).
    int  n_words, order_err, first_valid, last_cyc, last_cnt, done_cnt, done_cyc;
    int  busy_first, busy_last, post_rst_bad;
    longint last_word, chk_at_done;

    task automatic run_small(input int hold_from, input int hold_to, input int start2_cyc,
                             input int rst_cyc, input int max_cyc);
        n_words = 0; order_err = 0; first_valid = -1; last_cyc = -1; last_cnt = 0;
        done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1; post_rst_bad = 0;
        last_word = -1; chk_at_done = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (s_valid) begin
                if (first_valid < 0) first_valid = c;
                if (s_weight != 32'(n_words + 100)) order_err++;
                n_words++;
            end
            if (s_last) begin
                last_cnt++;
                last_cyc  = c;
                last_word = longint'(s_weight);
            end
            if (s_done) begin
                done_cnt++;
                done_cyc = c;
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
                chk_at_done = longint'(s_chksum);
`endif
            end
            if (s_busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (rst_cyc >= 0 && c > rst_cyc &&
                (s_valid || s_last || s_busy || s_done || s_rd_en || s_addr != '0 ||
                 s_weight != '0)) post_rst_bad++;
            s_start = (c == 0) || (c == start2_cyc);
            s_hold  = (c >= hold_from) && (c <= hold_to);
            s_reset = (c == rst_cyc);
        end
        s_start = 1'b0;
        s_hold  = 1'b0;
        s_reset = 1'b0;
    endtask

    int     b_n, b_err, b_first, b_last_cyc, b_last_cnt, b_done_cnt;
    longint b_last_word, b_max_addr;

    initial begin
        s_reset = 1'b1; s_start = 1'b0; s_hold = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_hold = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", longint'(s_valid), 0);
        check_eq("rst_weight", longint'(s_weight), 0);
        check_eq("rst_busy_done_last", longint'({s_busy, s_done, s_last}), 0);
        check_eq("rst_mem", longint'({s_rd_en, s_addr}), 0);
        check_eq("rst_big_outputs", longint'({b_valid, b_busy, b_done, b_last, b_rd_en}), 0);
        s_reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);

        // Plain stream
        run_small(1000, 999, -1, -1, 45);
        check_eq("a_first_valid", first_valid, 3);
        check_eq("a_words", n_words, 36);
        check_eq("a_order", order_err, 0);
        check_eq("a_last_cnt", last_cnt, 1);
        check_eq("a_last_cyc", last_cyc, 38);
        check_eq("a_last_word", last_word, 135);
        check_eq("a_done_cnt", done_cnt, 1);
        check_eq("a_done_cyc", done_cyc, 39);
        check_eq("a_busy_first", busy_first, 1);
        check_eq("a_busy_last", busy_last, 39);
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
        check_eq("a_chksum", chk_at_done, 4230);
`endif

        // hold for cycles 5..9: reads 0..3 then 5-cycle gap
        run_small(5, 9, -1, -1, 50);
        check_eq("b_words", n_words, 36);
        check_eq("b_order", order_err, 0);
        check_eq("b_last_cyc", last_cyc, 43);
        check_eq("b_last_word", last_word, 135);
        check_eq("b_done_cyc", done_cyc, 44);
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
        check_eq("b_chksum", chk_at_done, 4230);
`endif

        // Second start while busy is ignored
        run_small(1000, 999, 10, -1, 50);
        check_eq("c_words", n_words, 36);
        check_eq("c_order", order_err, 0);
        check_eq("c_done_cnt", done_cnt, 1);
        check_eq("c_last_cyc", last_cyc, 38);

        // Reset mid-stream at cycle 20
        run_small(1000, 999, -1, 20, 32);
        check_eq("d_words", n_words, 18);
        check_eq("d_order", order_err, 0);
        check_eq("d_done_cnt", done_cnt, 0);
        check_eq("d_post_rst_outputs", post_rst_bad, 0);

        // Fresh stream after the abort starts again from address 0
        run_small(1000, 999, -1, -1, 45);
        check_eq("e_first_valid", first_valid, 3);
        check_eq("e_words", n_words, 36);
        check_eq("e_order", order_err, 0);
        check_eq("e_done_cyc", done_cyc, 39);

        // Default parameters: 9408 back-to-back words
        b_n = 0; b_err = 0; b_first = -1; b_last_cyc = -1; b_last_cnt = 0; b_done_cnt = 0;
        b_last_word = -1; b_max_addr = 0;
        for (int c = 0; c < 9420; c++) begin
            @(negedge clk);
            if (b_valid) begin
                if (b_first < 0) b_first = c;
                if (b_weight != 32'(b_n)) b_err++;
                b_n++;
            end
            if (b_last) begin
                b_last_cnt++;
                b_last_cyc  = c;
                b_last_word = longint'(b_weight);
            end
            if (b_done) b_done_cnt++;
            if (b_rd_en && longint'(b_addr) > b_max_addr) b_max_addr = longint'(b_addr);
            b_start = (c == 0);
        end
        check_eq("f_words", b_n, 9408);
        check_eq("f_order", b_err, 0);
        check_eq("f_last_cnt", b_last_cnt, 1);
        check_eq("f_last_word", b_last_word, 9407);
        check_eq("f_back_to_back", b_last_cyc - b_first + 1, 9408);
        check_eq("f_max_addr", b_max_addr, 9407);
        check_eq("f_done_cnt", b_done_cnt, 1);
`ifdef CONV_WEIGHT_TX_CHKSUM_EN
        // sum 0..9407 = 44,250,528
        check_eq("f_chksum", longint'(b_chksum), 44250528);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
